// File: rtl/alt_mem_ddrx_id_tracker_pkg.sv
// Shared defaults for the DDRx controller ID tracker: ID width, ID count and
// the width of the per-command data-beat counter.
package alt_mem_ddrx_id_tracker_pkg;

  localparam int DEF_LIST_WIDTH = 3;
  localparam int DEF_LIST_DEPTH = 1 << DEF_LIST_WIDTH;
  localparam int DEF_BEAT_WIDTH = 4;

endpackage

// File: rtl/alt_mem_ddrx_id_tracker_penc.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module alt_mem_ddrx_id_tracker_penc #(
  parameter int CTL_LIST_DEPTH = 8,
  localparam int IDX_W = (CTL_LIST_DEPTH > 1) ? $clog2(CTL_LIST_DEPTH) : 1
) (
  input  logic [CTL_LIST_DEPTH-1:0] req,
  output logic                      any,
  output logic [IDX_W-1:0]          index
);

  // NOTE: assign every output before the loop so no path through the block
  // leaves a value unassigned; otherwise a latch is inferred.
  always_comb begin
    any   = |req;
    index = '0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = CTL_LIST_DEPTH - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alt_mem_ddrx_id_tracker.sv
// Tracks controller command IDs from allocation through data-beat completion
// to return of the ID to the external free list.
module alt_mem_ddrx_id_tracker
  import alt_mem_ddrx_id_tracker_pkg::*;
#(
  parameter int CTL_LIST_WIDTH = DEF_LIST_WIDTH,
  parameter int CTL_LIST_DEPTH = DEF_LIST_DEPTH,
  parameter int CTL_BEAT_WIDTH = DEF_BEAT_WIDTH
) (
  input  logic                      ctl_clk,
  input  logic                      ctl_reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CTL_BEAT_WIDTH-1:0] cmd_beats,
  output logic [CTL_LIST_WIDTH-1:0] cmd_id,
  input  logic                      list_get_entry_valid,
  output logic                      list_get_entry_ready,
  input  logic [CTL_LIST_WIDTH-1:0] list_get_entry_id,
  output logic                      list_put_entry_valid,
  input  logic                      list_put_entry_ready,
  output logic [CTL_LIST_WIDTH-1:0] list_put_entry_id,
  input  logic                      beat_valid,
  input  logic [CTL_LIST_WIDTH-1:0] beat_id,
  output logic [CTL_LIST_DEPTH-1:0] outstanding_vector,
  output logic [CTL_LIST_WIDTH:0]   outstanding_count,
  output logic                      err_beat
);

  logic [CTL_LIST_DEPTH-1:0] outstanding_q, outstanding_d;
  logic [CTL_LIST_DEPTH-1:0] pending_q, pending_d;
  logic [CTL_BEAT_WIDTH-1:0] beats_q [CTL_LIST_DEPTH];
  logic [CTL_BEAT_WIDTH-1:0] beats_d [CTL_LIST_DEPTH];
  logic [CTL_LIST_WIDTH:0]   count_q, count_d;
  logic                      err_q, err_d;

  logic                      alloc, beat_ok, retire, put_fire, put_any;
  logic [CTL_BEAT_WIDTH-1:0] beat_cnt, load_beats;
  logic [CTL_LIST_WIDTH-1:0] put_idx;

  assign cmd_ready            = list_get_entry_valid;
  assign list_get_entry_ready = cmd_valid;
  assign cmd_id               = list_get_entry_id;

  assign alloc      = cmd_valid & list_get_entry_valid;
  assign beat_cnt   = beats_q[beat_id];
  assign load_beats = (cmd_beats == '0) ? CTL_BEAT_WIDTH'(1) : cmd_beats;
  // A beat racing the allocation of its own ID cannot belong to that command.
  assign beat_ok    = beat_valid & outstanding_q[beat_id]
                    & ~(alloc & (beat_id == list_get_entry_id));
  assign retire     = beat_ok & (beat_cnt == CTL_BEAT_WIDTH'(1));
  assign put_fire   = put_any & list_put_entry_ready;

  alt_mem_ddrx_id_tracker_penc #(
    .CTL_LIST_DEPTH (CTL_LIST_DEPTH)
  ) u_put_penc (
    .req   (pending_q),
    .any   (put_any),
    .index (put_idx)
  );

  assign list_put_entry_valid = put_any;
  assign list_put_entry_id    = put_idx;
  assign outstanding_vector   = outstanding_q;
  assign outstanding_count    = count_q;
  assign err_beat             = err_q;

  // NOTE: combinational next-state logic uses blocking assignments so later
  // statements see earlier updates; the state registers below use <= only.
  always_comb begin
    outstanding_d = outstanding_q;
    pending_d     = pending_q;
    beats_d       = beats_q;
    count_d       = count_q;
    err_d         = err_q;

    // The put ID is pending and the retiring ID is outstanding, so they differ.
    if (put_fire) pending_d[put_idx] = 1'b0;

    if (beat_ok) begin
      if (retire) begin
        outstanding_d[beat_id] = 1'b0;
        beats_d[beat_id]       = '0;
        pending_d[beat_id]     = 1'b1;
      end else begin
        beats_d[beat_id] = beat_cnt - 1'b1;
      end
    end
    if (beat_valid && !beat_ok) err_d = 1'b1;

    if (alloc) begin
      outstanding_d[list_get_entry_id] = 1'b1;
      beats_d[list_get_entry_id]       = load_beats;
    end

    case ({alloc, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the beat-count array is reset along with the flags because a reset
  // may land mid-operation and stale counts would corrupt the next command.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      outstanding_q <= '0;
      pending_q     <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < CTL_LIST_DEPTH; i++) beats_q[i] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      pending_q     <= pending_d;
      count_q       <= count_d;
      err_q         <= err_d;
      beats_q       <= beats_d;
    end
  end

endmodule

// File: tb/tb_alt_mem_ddrx_id_tracker.sv
// Directed self-checking bench for the ID tracker; returned IDs are checked
// against a queue of expected put IDs filled as retiring beats are driven.
module tb_alt_mem_ddrx_id_tracker;

  logic       ctl_clk = 1'b0;
  logic       ctl_reset_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_beats;
  logic [2:0] cmd_id;
  logic       list_get_entry_valid, list_get_entry_ready;
  logic [2:0] list_get_entry_id;
  logic       list_put_entry_valid, list_put_entry_ready;
  logic [2:0] list_put_entry_id;
  logic       beat_valid;
  logic [2:0] beat_id;
  logic [7:0] outstanding_vector;
  logic [3:0] outstanding_count;
  logic       err_beat;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_put[$];

  alt_mem_ddrx_id_tracker dut (
    .ctl_clk              (ctl_clk),
    .ctl_reset_n          (ctl_reset_n),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_beats            (cmd_beats),
    .cmd_id               (cmd_id),
    .list_get_entry_valid (list_get_entry_valid),
    .list_get_entry_ready (list_get_entry_ready),
    .list_get_entry_id    (list_get_entry_id),
    .list_put_entry_valid (list_put_entry_valid),
    .list_put_entry_ready (list_put_entry_ready),
    .list_put_entry_id    (list_put_entry_id),
    .beat_valid           (beat_valid),
    .beat_id              (beat_id),
    .outstanding_vector   (outstanding_vector),
    .outstanding_count    (outstanding_count),
    .err_beat             (err_beat)
  );

  always #5 ctl_clk = ~ctl_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_put(input string tag);
    int e;
    if (exp_put.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed put id 0x%0h expected scoreboard entry (queue empty)",
             tag, list_put_entry_id);
    end else begin
      e = exp_put.pop_front();
      check({tag, "_valid"}, 32'(list_put_entry_valid), 32'd1);
      check({tag, "_id"}, 32'(list_put_entry_id), 32'(e));
    end
  endtask

  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic idle();
    cmd_valid            = 1'b0;
    cmd_beats            = 4'd0;
    list_get_entry_valid = 1'b0;
    list_put_entry_ready = 1'b0;
    beat_valid           = 1'b0;
  endtask

  task automatic alloc(input logic [2:0] id, input logic [3:0] beats);
    cmd_valid            = 1'b1;
    list_get_entry_valid = 1'b1;
    list_get_entry_id    = id;
    cmd_beats            = beats;
    tick();
    idle();
  endtask

  task automatic beat(input logic [2:0] id);
    beat_valid = 1'b1;
    beat_id    = id;
    tick();
    beat_valid = 1'b0;
  endtask

  initial begin
    idle();
    list_get_entry_id = 3'd0;
    beat_id           = 3'd0;

    // Reset: combinational paths still follow their inputs.
    ctl_reset_n          = 1'b0;
    list_get_entry_valid = 1'b1;
    list_get_entry_id    = 3'd3;
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cmd_id", 32'(cmd_id), 32'd3);
    check("rst_get_ready", 32'(list_get_entry_ready), 32'd0);
    check("rst_put_valid", 32'(list_put_entry_valid), 32'd0);
    check("rst_vector", 32'(outstanding_vector), 32'h00);
    check("rst_count", 32'(outstanding_count), 32'd0);
    check("rst_err", 32'(err_beat), 32'd0);
    @(negedge ctl_clk);
    ctl_reset_n = 1'b1;
    idle();
    tick();

    // Allocate ID 0 with four beats.
    cmd_valid            = 1'b1;
    list_get_entry_valid = 1'b1;
    list_get_entry_id    = 3'd0;
    cmd_beats            = 4'd4;
    #1;
    check("s1_cmd_ready", 32'(cmd_ready), 32'd1);
    check("s1_get_ready", 32'(list_get_entry_ready), 32'd1);
    check("s1_cmd_id", 32'(cmd_id), 32'd0);
    tick();
    idle();
    check("s1_vector", 32'(outstanding_vector), 32'h01);
    check("s1_count", 32'(outstanding_count), 32'd1);

    // Four beats retire ID 0; it must wait for the return handshake.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_put.push_back(0);
      beat(3'd0);
      if (i < 3) begin
        check($sformatf("s2_vector_b%0d", i), 32'(outstanding_vector), 32'h01);
        check($sformatf("s2_putv_b%0d", i), 32'(list_put_entry_valid), 32'd0);
      end
    end
    check("s2_vector", 32'(outstanding_vector), 32'h00);
    check("s2_count", 32'(outstanding_count), 32'd0);
    check_put("s2_put0");
    list_put_entry_ready = 1'b1;
    tick();
    list_put_entry_ready = 1'b0;
    check("s2_put_cleared", 32'(list_put_entry_valid), 32'd0);

    // IDs 2 and 5 retire out of order; returns come back lowest first.
    alloc(3'd2, 4'd1);
    alloc(3'd5, 4'd0);
    check("s3_vector", 32'(outstanding_vector), 32'h24);
    check("s3_count", 32'(outstanding_count), 32'd2);
    beat(3'd5);
    check("s3_vector_b5", 32'(outstanding_vector), 32'h04);
    check("s3_count_b5", 32'(outstanding_count), 32'd1);
    beat(3'd2);
    exp_put.push_back(2);
    exp_put.push_back(5);
    check("s3_vector_b2", 32'(outstanding_vector), 32'h00);
    check("s3_count_b2", 32'(outstanding_count), 32'd0);
    tick();
    list_put_entry_ready = 1'b1;
    #1;
    check_put("s3_put_a");
    tick();
    check_put("s3_put_b");
    tick();
    list_put_entry_ready = 1'b0;
    check("s3_put_drained", 32'(list_put_entry_valid), 32'd0);

    // Allocate, retire and put on three distinct IDs in one cycle.
    alloc(3'd1, 4'd1);
    alloc(3'd6, 4'd1);
    exp_put.push_back(6);
    beat(3'd6);
    check("s4_pre_vector", 32'(outstanding_vector), 32'h02);
    check("s4_pre_count", 32'(outstanding_count), 32'd1);
    cmd_valid            = 1'b1;
    list_get_entry_valid = 1'b1;
    list_get_entry_id    = 3'd3;
    cmd_beats            = 4'd2;
    beat_valid           = 1'b1;
    beat_id              = 3'd1;
    list_put_entry_ready = 1'b1;
    #1;
    check_put("s4_put6");
    exp_put.push_back(1);
    tick();
    idle();
    check("s4_vector", 32'(outstanding_vector), 32'h08);
    check("s4_count", 32'(outstanding_count), 32'd1);
    check_put("s4_put1");
    list_put_entry_ready = 1'b1;
    tick();
    list_put_entry_ready = 1'b0;
    beat(3'd3);
    check("s4_vector_b3a", 32'(outstanding_vector), 32'h08);
    exp_put.push_back(3);
    beat(3'd3);
    check("s4_vector_b3b", 32'(outstanding_vector), 32'h00);
    check("s4_count_b3b", 32'(outstanding_count), 32'd0);
    check_put("s4_put3");
    list_put_entry_ready = 1'b1;
    tick();
    list_put_entry_ready = 1'b0;
    check("s4_put_drained", 32'(list_put_entry_valid), 32'd0);

    // Beat on a free ID flags an error and touches nothing else.
    check("s5_err_before", 32'(err_beat), 32'd0);
    beat(3'd7);
    check("s5_err", 32'(err_beat), 32'd1);
    check("s5_vector", 32'(outstanding_vector), 32'h00);
    check("s5_count", 32'(outstanding_count), 32'd0);
    check("s5_put_valid", 32'(list_put_entry_valid), 32'd0);
    repeat (3) tick();
    check("s5_err_sticky", 32'(err_beat), 32'd1);

    // Reset mid-operation with three outstanding and two pending.
    for (int i = 0; i < 5; i++) alloc(3'(i), (i < 3) ? 4'd2 : 4'd1);
    beat(3'd3);
    beat(3'd4);
    check("s6_vector", 32'(outstanding_vector), 32'h07);
    check("s6_count", 32'(outstanding_count), 32'd3);
    check("s6_put_valid", 32'(list_put_entry_valid), 32'd1);
    #2;
    ctl_reset_n          = 1'b0;
    list_get_entry_valid = 1'b1;
    list_get_entry_id    = 3'd6;
    #1;
    check("s6_rst_vector", 32'(outstanding_vector), 32'h00);
    check("s6_rst_count", 32'(outstanding_count), 32'd0);
    check("s6_rst_put_valid", 32'(list_put_entry_valid), 32'd0);
    check("s6_rst_err", 32'(err_beat), 32'd0);
    check("s6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("s6_rst_cmd_id", 32'(cmd_id), 32'd6);
    exp_put.delete();
    @(negedge ctl_clk);
    ctl_reset_n = 1'b1;
    idle();
    tick();

    // Beat colliding with the allocation of its own ID.
    beat_valid = 1'b1;
    beat_id    = 3'd4;
    alloc(3'd4, 4'd1);
    beat_valid = 1'b0;
    check("s7_err", 32'(err_beat), 32'd1);
    check("s7_vector", 32'(outstanding_vector), 32'h10);
    check("s7_count", 32'(outstanding_count), 32'd1);
    exp_put.push_back(4);
    beat(3'd4);
    check("s7_vector_b4", 32'(outstanding_vector), 32'h00);
    check("s7_count_b4", 32'(outstanding_count), 32'd0);
    check_put("s7_put4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alt_mem_ddrx_id_tracker.md
ALT_MEM_DDRX_ID_TRACKER -- requirements
Module: alt_mem_ddrx_id_tracker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CTL_LIST_WIDTH, 3: ID width.
- CTL_LIST_DEPTH, 8: number of IDs, equal to 2**CTL_LIST_WIDTH.
- CTL_BEAT_WIDTH, 4: width of the per-command beat count.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- ctl_clk, in, 1: clock.
- ctl_reset_n, in, 1: reset, asynchronous, active-low; clock is ctl_clk.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when high with cmd_valid.
- cmd_beats, in, CTL_BEAT_WIDTH: data beats owed to the command.
- cmd_id, out, CTL_LIST_WIDTH: ID assigned to the accepted command.
- list_get_entry_valid, in, 1: free-list head valid.
- list_get_entry_ready, out, 1: pop of the free-list head.
- list_get_entry_id, in, CTL_LIST_WIDTH: free-list head ID.
- list_put_entry_valid, out, 1: ID return request.
- list_put_entry_ready, in, 1: free list can accept a return.
- list_put_entry_id, out, CTL_LIST_WIDTH: returned ID.
- beat_valid, in, 1: one completion beat.
- beat_id, in, CTL_LIST_WIDTH: ID the beat belongs to.
- outstanding_vector, out, CTL_LIST_DEPTH: one-hot-per-ID, allocated and not yet retired.
- outstanding_count, out, CTL_LIST_WIDTH+1: population of outstanding_vector.
- err_beat, out, 1: sticky flag for a beat on a non-outstanding ID.

Function
REQ-003 cmd_ready SHALL equal list_get_entry_valid, list_get_entry_ready SHALL equal cmd_valid, and cmd_id SHALL equal list_get_entry_id; these paths are combinational with zero latency.
REQ-004 The allocation condition SHALL be cmd_valid & list_get_entry_valid. On allocation, the next edge SHALL set outstanding[cmd_id] and load beats[cmd_id] with cmd_beats.
REQ-005 A cmd_beats value of 0 SHALL be loaded as 1.
REQ-006 A beat on an outstanding ID whose count is greater than 1 SHALL decrement that count by 1 on the next edge.
REQ-007 A beat on an outstanding ID whose count equals 1 SHALL, on the next edge:
- clear outstanding[id];
- clear the count;
- set pending[id] (retired, awaiting return).
REQ-008 A beat on a non-outstanding ID SHALL be ignored for all state and SHALL set err_beat.
REQ-009 If a beat targets the ID being allocated in the same cycle, the allocation SHALL take effect and the beat SHALL set err_beat.
REQ-010 list_put_entry_valid SHALL equal the OR of the pending vector. list_put_entry_id SHALL be the lowest-index pending ID, selected combinationally.
REQ-011 A put handshake (list_put_entry_valid & list_put_entry_ready) SHALL clear pending[list_put_entry_id] on the next edge.
REQ-012 While list_put_entry_ready is low, pending IDs SHALL accumulate; the pending vector cannot overflow because each ID is pending at most once.
REQ-013 Allocation, beat retirement and put SHALL all take effect in the same cycle when they target distinct IDs.
REQ-014 outstanding_count SHALL:
- increment on allocation;
- decrement on retirement;
- hold when both occur in the same cycle;
- never wrap, since it is bounded by CTL_LIST_DEPTH.
REQ-015 Every state update SHALL be registered on the rising edge of ctl_clk. Only REQ-003 and REQ-010 outputs are combinational.

Reset
REQ-016 Asserting ctl_reset_n low SHALL asynchronously clear outstanding, pending, every beat count, outstanding_count and err_beat, including mid-operation. The free list is reset by the same signal and restores its IDs.
REQ-017 Under reset:
- list_put_entry_valid, outstanding_vector and outstanding_count SHALL be 0;
- cmd_ready, list_get_entry_ready and cmd_id SHALL follow their REQ-003 inputs.

Structure
REQ-018 CTL_LIST_WIDTH, CTL_LIST_DEPTH and CTL_BEAT_WIDTH defaults SHALL live in the shared alt_mem_ddrx package.
REQ-019 The lowest-set-bit priority encoder SHALL be the sub-module alt_mem_ddrx_id_tracker_penc (parameter CTL_LIST_DEPTH; outputs any and index).
REQ-020 Total RTL SHALL be single-clock.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then free list presenting ID 0 valid with cmd_valid high and cmd_beats=4 -> cmd_id=0; next cycle outstanding_vector=8'h01, outstanding_count=1.
- Four beats on ID 0 -> count steps 4,3,2,1; after the fourth beat pending[0]=1, list_put_entry_valid=1, list_put_entry_id=0, outstanding_count=0.
- Allocate IDs 2 and 5 (beats=1 each), hold list_put_entry_ready low, beat ID 5 then ID 2 -> put presents 2 first, then 5, once ready rises.
- In one cycle: allocate ID 3, final beat on ID 1, put handshake of ID 6 -> all three updates occur; outstanding_count unchanged.
- Beat on ID 7 while ID 7 is free -> err_beat=1 and stays high; no other state changes.
- Reset asserted with 3 IDs outstanding and 2 pending -> all vectors and counts 0 immediately, list_put_entry_valid=0.
